// File: rtl/vga_timing_pkg.sv
// Shared timing constants, counter widths and the vertical state type for the VGA frame path.
package vga_timing_pkg;

  localparam int unsigned CycleW = 11;
  localparam int unsigned LineW  = 10;
  localparam int unsigned AddrW  = 14;
  localparam int unsigned RepW   = 3;

  localparam int unsigned DefLineCycles  = 1792;
  localparam int unsigned DefVSyncLines  = 2;
  localparam int unsigned DefVBpLines    = 29;
  localparam int unsigned DefVActLines   = 480;
  localparam int unsigned DefVFpLines    = 10;
  localparam int unsigned DefRowRepeat   = 5;
  localparam logic [AddrW-1:0] DefRowStride = 14'h40;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StBporch,
    StActive,
    StFporch
  } vga_state_e;

endpackage

// File: rtl/vga_line_timer.sv
// Cycle counter within a line; emits a one-cycle line_tick on the last cycle of each line.
module vga_line_timer
  import vga_timing_pkg::*;
#(
  parameter int unsigned LINE_CYCLES = DefLineCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic line_tick
);

  localparam logic [CycleW-1:0] LastCycle = CycleW'(LINE_CYCLES - 1);

  logic [CycleW-1:0] cnt_q, cnt_d;

  always_comb begin
    line_tick = !clear && (cnt_q == LastCycle);
    if (clear || line_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Vertical frame sequencer: lines/frames, v_sync, h_sync_en gating and VRAM row base.
// Optional vblank interrupt enabled by defining VGA_VBLANK_IRQ_EN.
module vga_frame_sequencer
  import vga_timing_pkg::*;
#(
  parameter int unsigned       LINE_CYCLES    = DefLineCycles,
  parameter int unsigned       V_SYNC_LINES   = DefVSyncLines,
  parameter int unsigned       V_BP_LINES     = DefVBpLines,
  parameter int unsigned       V_ACTIVE_LINES = DefVActLines,
  parameter int unsigned       V_FP_LINES     = DefVFpLines,
  parameter int unsigned       ROW_REPEAT     = DefRowRepeat,
  parameter logic [AddrW-1:0]  ROW_STRIDE     = DefRowStride
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             h_sync_en,
  output logic             v_sync,
  output logic             line_active,
  output logic [LineW-1:0] line_count,
  output logic [AddrW-1:0] row_addr,
  output logic             frame_start
`ifdef VGA_VBLANK_IRQ_EN
  ,
  output logic             vblank_irq,
  input  logic             irq_ack
`endif
);

  localparam int unsigned Total = V_SYNC_LINES + V_BP_LINES + V_ACTIVE_LINES + V_FP_LINES;

  localparam logic [LineW-1:0] LastSync = LineW'(V_SYNC_LINES - 1);
  localparam logic [LineW-1:0] LastBp   = LineW'(V_SYNC_LINES + V_BP_LINES - 1);
  localparam logic [LineW-1:0] LastAct  = LineW'(V_SYNC_LINES + V_BP_LINES + V_ACTIVE_LINES - 1);
  localparam logic [LineW-1:0] LastLine = LineW'(Total - 1);
  localparam logic [RepW-1:0]  LastRep  = RepW'(ROW_REPEAT - 1);

  vga_state_e       state_q, state_d;
  logic [LineW-1:0] line_q, line_d;
  logic [AddrW-1:0] row_q, row_d;
  logic [RepW-1:0]  rep_q, rep_d;
  logic             fs_q, fs_d;
  logic             hse_q, vs_q, act_q;
  logic             line_tick;
  logic             timer_clear;

  // Timer is held at zero while idle so the first VSYNC cycle is cycle 0.
  assign timer_clear = !enable || (state_q == StIdle);

  vga_line_timer #(
    .LINE_CYCLES (LINE_CYCLES)
  ) u_line_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .line_tick (line_tick)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    row_d   = row_q;
    rep_d   = rep_q;
    fs_d    = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      line_d  = '0;
      row_d   = '0;
      rep_d   = '0;
    end else if (state_q == StIdle) begin
      state_d = StVsync;
      line_d  = '0;
      row_d   = '0;
      rep_d   = '0;
      fs_d    = 1'b1;
    end else if (line_tick) begin
      line_d = (line_q == LastLine) ? '0 : line_q + 1'b1;
      unique case (state_q)
        StVsync:  if (line_q == LastSync) state_d = StBporch;
        StBporch: if (line_q == LastBp) state_d = StActive;
        StActive: begin
          if (rep_q == LastRep) begin
            rep_d = '0;
            row_d = row_q + ROW_STRIDE;
          end else begin
            rep_d = rep_q + 1'b1;
          end
          if (line_q == LastAct) state_d = StFporch;
        end
        StFporch: begin
          if (line_q == LastLine) begin
            state_d = StVsync;
            row_d   = '0;
            rep_d   = '0;
            fs_d    = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      line_q  <= '0;
      row_q   <= '0;
      rep_q   <= '0;
      fs_q    <= 1'b0;
      hse_q   <= 1'b0;
      vs_q    <= 1'b1;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      row_q   <= row_d;
      rep_q   <= rep_d;
      fs_q    <= fs_d;
      hse_q   <= (state_d != StIdle);
      vs_q    <= (state_d != StVsync);
      act_q   <= (state_d == StActive);
    end
  end

  assign h_sync_en   = hse_q;
  assign v_sync      = vs_q;
  assign line_active = act_q;
  assign line_count  = line_q;
  assign row_addr    = row_q;
  assign frame_start = fs_q;

`ifdef VGA_VBLANK_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (irq_ack) irq_d = 1'b0;
    if ((state_q == StActive) && (state_d == StFporch)) irq_d = 1'b1;
    if (state_d == StIdle) irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign vblank_irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Bench for vga_frame_sequencer with a small frame geometry; the model maps elapsed clocks
// since frame start directly to expected outputs. Covers VGA_VBLANK_IRQ_EN when defined.
module tb_vga_frame_sequencer;

  localparam int LC     = 16;
  localparam int S      = 2;
  localparam int B      = 3;
  localparam int A      = 10;
  localparam int F      = 2;
  localparam int TOTAL  = S + B + A + F;
  localparam int FRAME  = TOTAL * LC;
  localparam int RR     = 5;
  localparam int STRIDE = 64;
  localparam int SET_T  = (S + B + A) * LC;

  typedef struct packed {
    logic       h;
    logic       v;
    logic       act;
    logic       fs;
    logic [9:0] line;
    logic [13:0] row;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        h_sync_en;
  logic        v_sync;
  logic        line_active;
  logic [9:0]  line_count;
  logic [13:0] row_addr;
  logic        frame_start;
`ifdef VGA_VBLANK_IRQ_EN
  logic        vblank_irq;
  logic        irq_ack;
  logic        irq_m;
`endif

  exp_t obs;
  assign obs = {h_sync_en, v_sync, line_active, frame_start, line_count, row_addr};

  int checks;
  int errors;
  int t;  // clocks since frame start; -1 while idle

  vga_frame_sequencer #(
    .LINE_CYCLES    (LC),
    .V_SYNC_LINES   (S),
    .V_BP_LINES     (B),
    .V_ACTIVE_LINES (A),
    .V_FP_LINES     (F),
    .ROW_REPEAT     (RR),
    .ROW_STRIDE     (14'h40)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .h_sync_en   (h_sync_en),
    .v_sync      (v_sync),
    .line_active (line_active),
    .line_count  (line_count),
    .row_addr    (row_addr),
    .frame_start (frame_start)
`ifdef VGA_VBLANK_IRQ_EN
    ,
    .vblank_irq  (vblank_irq),
    .irq_ack     (irq_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(int tt);
    exp_t e;
    int   line;
    int   done;
    e = '{h: 1'b0, v: 1'b1, act: 1'b0, fs: 1'b0, line: 10'd0, row: 14'd0};
    if (tt >= 0) begin
      line = (tt / LC) % TOTAL;
      done = line - (S + B);
      if (done < 0) done = 0;
      if (done > A) done = A;
      e.h    = 1'b1;
      e.v    = (line >= S);
      e.act  = (line >= S + B) && (line < S + B + A);
      e.fs   = ((tt % FRAME) == 0);
      e.line = 10'(line);
      e.row  = 14'((done / RR) * STRIDE);
    end
    return e;
  endfunction

  task automatic advance();
    @(posedge clk);
    if (!reset || !enable) t = -1;
    else if (t < 0) t = 0;
    else t = t + 1;
`ifdef VGA_VBLANK_IRQ_EN
    if (!reset || !enable) begin
      irq_m = 1'b0;
    end else begin
      if (irq_ack) irq_m = 1'b0;
      if ((t % FRAME) == SET_T) irq_m = 1'b1;
    end
`endif
    @(negedge clk);
  endtask

  task automatic start_frame();
    enable = 1'b0;
    advance();
    enable = 1'b1;
    advance();
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== model(-1)) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", obs, model(-1));
    end
    enable = 1'b1;
    advance();
    checks++;
    if (obs !== model(-1)) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", obs, model(-1));
    end
    reset = 1'b1;
    advance();
    checks++;
    if (!(h_sync_en === 1'b1 && v_sync === 1'b0 && frame_start === 1'b1) || obs !== model(t)) begin
      errors++;
      $display("FAIL first_clock got=%h exp=%h", obs, model(t));
    end
    advance();
    checks++;
    if (frame_start !== 1'b0 || obs !== model(t)) begin
      errors++;
      $display("FAIL fs_single got=%h exp=%h", obs, model(t));
    end
  endtask

  task automatic test_frame_timing();
    int vlow, fs_cnt, rise, fall;
    logic prev;
    vlow = 0; fs_cnt = 0; rise = -1; fall = -1; prev = 1'b0;
    start_frame();
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs !== model(t)) begin
        errors++;
        $display("FAIL frame t=%0d got=%h exp=%h", t, obs, model(t));
      end
      if (v_sync === 1'b0) vlow++;
      if (frame_start === 1'b1) fs_cnt++;
      if (line_active === 1'b1 && !prev) rise = int'(line_count);
      if (line_active === 1'b0 && prev) fall = int'(line_count);
      prev = line_active;
      advance();
    end
    checks++;
    if (vlow != S * LC) begin
      errors++;
      $display("FAIL vsync_width got=%0d exp=%0d", vlow, S * LC);
    end
    checks++;
    if (fs_cnt != 1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL fs_period got=%0d/%b exp=1/1", fs_cnt, frame_start);
    end
    checks++;
    if (rise != S + B || fall != S + B + A) begin
      errors++;
      $display("FAIL active_window got=%0d..%0d exp=%0d..%0d", rise, fall, S + B, S + B + A);
    end
  endtask

  task automatic test_row_addr();
    start_frame();
    while (t < 10 * LC) advance();
    checks++;
    if (row_addr !== 14'h040) begin
      errors++;
      $display("FAIL row_step1 got=%h exp=040", row_addr);
    end
    while (t < 15 * LC) advance();
    checks++;
    if (row_addr !== 14'h080) begin
      errors++;
      $display("FAIL row_step2 got=%h exp=080", row_addr);
    end
    while (t < FRAME) advance();
    checks++;
    if (row_addr !== 14'h000 || v_sync !== 1'b0) begin
      errors++;
      $display("FAIL row_clear got=%h/%b exp=000/0", row_addr, v_sync);
    end
  endtask

  task automatic test_enable_drop();
    start_frame();
    for (int i = 0; i < FRAME && t < 7 * LC + 3; i++) advance();
    checks++;
    if (line_count !== 10'd7 || obs !== model(t)) begin
      errors++;
      $display("FAIL pre_drop got=%h exp=%h", obs, model(t));
    end
    enable = 1'b0;
    advance();
    checks++;
    if (obs !== exp_t'({1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 14'd0})) begin
      errors++;
      $display("FAIL drop got=%h exp=%h", obs, model(-1));
    end
    advance();
    enable = 1'b1;
    advance();
    checks++;
    if (frame_start !== 1'b1 || line_count !== 10'd0 || obs !== model(t)) begin
      errors++;
      $display("FAIL reenable got=%h exp=%h", obs, model(t));
    end
  endtask

  task automatic test_random_enable();
    int n;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 600);
      for (int i = 0; i < n; i++) begin
        advance();
        checks++;
        if (obs !== model(t)) begin
          errors++;
          $display("FAIL rand_run t=%0d got=%h exp=%h", t, obs, model(t));
        end
      end
      enable = 1'b0;
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        advance();
        checks++;
        if (obs !== model(t)) begin
          errors++;
          $display("FAIL rand_idle got=%h exp=%h", obs, model(t));
        end
      end
      enable = 1'b1;
    end
  endtask

`ifdef VGA_VBLANK_IRQ_EN
  task automatic test_vblank_irq();
    start_frame();
    for (int i = 0; i < 2 * FRAME; i++) begin
      irq_ack = ($urandom_range(0, 7) == 0);
      advance();
      checks++;
      if (vblank_irq !== irq_m || obs !== model(t)) begin
        errors++;
        $display("FAIL irq_rand t=%0d got=%b exp=%b", t, vblank_irq, irq_m);
      end
    end
    irq_ack = 1'b0;
    for (int i = 0; i < FRAME && (t % FRAME) != SET_T - 2; i++) advance();
    irq_ack = 1'b1;
    advance();
    checks++;
    if (vblank_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ack got=%b exp=0", vblank_irq);
    end
    advance();
    checks++;
    if (vblank_irq !== 1'b1 || irq_m !== 1'b1) begin
      errors++;
      $display("FAIL irq_set_wins got=%b exp=1", vblank_irq);
    end
    irq_ack = 1'b0;
    enable  = 1'b0;
    advance();
    checks++;
    if (vblank_irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_idle got=%b exp=0", vblank_irq);
    end
    enable = 1'b1;
  endtask
`endif

  task automatic test_async_reset();
    start_frame();
    while (t < 8 * LC + 5) advance();
    checks++;
    if (line_active !== 1'b1) begin
      errors++;
      $display("FAIL pre_areset got=%b exp=1", line_active);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (obs !== model(-1)) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, model(-1));
    end
    t = -1;
`ifdef VGA_VBLANK_IRQ_EN
    irq_m = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
    advance();
    checks++;
    if (frame_start !== 1'b1 || obs !== model(t)) begin
      errors++;
      $display("FAIL post_areset got=%h exp=%h", obs, model(t));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    t      = -1;
    reset  = 1'b0;
    enable = 1'b0;
`ifdef VGA_VBLANK_IRQ_EN
    irq_ack = 1'b0;
    irq_m   = 1'b0;
`endif
    test_reset();
    test_frame_timing();
    test_row_addr();
    test_enable_drop();
    test_random_enable();
`ifdef VGA_VBLANK_IRQ_EN
    test_vblank_irq();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Vertical frame controller for the VGA output path. Counts master-clock cycles into lines and lines into frames, drives `v_sync`, and gates the horizontal line generator through `h_sync_en`. Also supplies the VRAM row base address for each displayed line. It sits between the top-level display enable and the horizontal sync/pixel block, sequencing that block once per line.

## Interface
Parameters:
- `LINE_CYCLES`, 1792: clocks per line; must match the horizontal generator period.
- `V_SYNC_LINES`, 2: lines with `v_sync` low.
- `V_BP_LINES`, 29: back-porch lines.
- `V_ACTIVE_LINES`, 480: displayed lines.
- `V_FP_LINES`, 10: front-porch lines.
- `ROW_REPEAT`, 5: displayed lines per VRAM row (vertical scale).
- `ROW_STRIDE`, 14'h40: VRAM address step per row.

Ports:
- `clk` in 1: master clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; level-sensitive.
- `h_sync_en` out 1: enable to the horizontal generator.
- `v_sync` out 1: vertical sync, active low.
- `line_active` out 1: current line is in the display region.
- `line_count` out 10: line index within the frame, 0..TOTAL-1.
- `row_addr` out 14: VRAM base address of the current row.
- `frame_start` out 1: single-cycle pulse at line 0, cycle 0.
- `vblank_irq` out 1: only with `VGA_VBLANK_IRQ_EN`.
- `irq_ack` in 1: only with `VGA_VBLANK_IRQ_EN`.

## Operation
- Definition: TOTAL = V_SYNC_LINES + V_BP_LINES + V_ACTIVE_LINES + V_FP_LINES, which is 521 at defaults.
- States:
  - IDLE: `enable` sampled low, or just out of reset.
  - VSYNC: lines 0..V_SYNC_LINES-1.
  - BPORCH: the back-porch lines.
  - ACTIVE: the display lines.
  - FPORCH: the front-porch lines.
- IDLE → VSYNC on the first cycle `enable` is sampled high. At that point the cycle counter, `line_count`, `row_addr` and the row-repeat counter all clear.
- Line tick: the cycle counter (11 bit) wraps at LINE_CYCLES-1. On wrap, `line_count` increments, or wraps to 0 at TOTAL-1.
- State advances only on a line tick, at the boundary the parameters imply. FPORCH → VSYNC on the wrap to line 0.
- `frame_start` fires on the cycle that re-enters VSYNC at line 0, and also on IDLE → VSYNC.
- `h_sync_en` = 1 in every non-IDLE state.
- `v_sync` = 0 in VSYNC only.
- `line_active` = 1 in ACTIVE only.
- Row addressing:
  - Each line tick that ends an ACTIVE line increments the 3-bit repeat counter.
  - At ROW_REPEAT-1 the repeat counter clears and `row_addr` += ROW_STRIDE, modulo 2^14.
  - `row_addr` clears to 0 on entry to VSYNC.
- `enable` dropping in any state sends the block to IDLE on the next edge, with all outputs at their reset values. There is no frame completion.
- Reset mid-frame: the block is immediately in IDLE and all counters are 0.

## Timing
- Reset values:
  - `h_sync_en` = 0, `v_sync` = 1, `line_active` = 0.
  - `line_count` = 0, `row_addr` = 0.
  - `frame_start` = 0, `vblank_irq` = 0.
- All outputs are registered. Latency from `enable` high to `h_sync_en` = 1 is 1 clock.
- Line tick and the state change land on the same edge. `line_count` and the state outputs update together.
- Frame length is TOTAL × LINE_CYCLES clocks: 933,632 at defaults.
- `enable` low and a line tick on the same cycle: the drop wins.

## Configuration
- `VGA_VBLANK_IRQ_EN` defined:
  - `vblank_irq` sets on the ACTIVE → FPORCH transition and holds until `irq_ack` is sampled high.
  - Set and ack on the same cycle: set wins.
  - `vblank_irq` clears on IDLE entry.
- Not defined: the `vblank_irq` and `irq_ack` ports and their logic are absent.

## Structure
- Shared package `vga_timing_pkg`:
  - state enum: IDLE, VSYNC, BPORCH, ACTIVE, FPORCH.
  - default timing constants.
  - counter width constants.
- Sub-module `vga_line_timer`:
  - holds the cycle counter.
  - outputs a one-cycle `line_tick`.
  - has a synchronous clear from IDLE.

## Test plan
- Reset low, then high with `enable`=1 → after 1 clock `h_sync_en`=1, `v_sync`=0, `frame_start`=1 for exactly one cycle.
- Run with LINE_CYCLES=16 and lines 2/3/10/2 (TOTAL=17):
  - `v_sync` is low for 32 clocks.
  - `line_active` rises at line 5 and falls at line 15.
  - `frame_start` repeats every 272 clocks.
- ROW_REPEAT=5, 10 active lines → `row_addr` steps 0x000 → 0x040 after 5 active lines and reaches 0x080 after 10. It clears to 0 at the next VSYNC.
- `enable` dropped at line 7, cycle 3 → next clock all outputs are at reset values. Re-enable restarts at line 0 with `frame_start`.
- With `VGA_VBLANK_IRQ_EN`: `vblank_irq` rises at the end of the last active line. `irq_ack` asserted on the same cycle as the next frame's set leaves `vblank_irq`=1.
- Async reset asserted mid-ACTIVE → outputs go to reset values without waiting for a clock edge.
